// File: rtl/stream_in_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stream_in_loader_if                                                  |
// | Character stream bundle (data/last/valid/ready) feeding the loader.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface stream_in_loader_if #(
    parameter int CHAR_LEN = 8
);
    logic [CHAR_LEN-1:0] tdata;
    logic                tlast;
    logic                tvalid;
    logic                tready;

    modport master (output tdata, output tlast, output tvalid, input  tready);
    modport slave  (input  tdata, input  tlast, input  tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/stream_in_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stream_in_loader                                                     |
// | Buffers one BATCH_SIZE*N character frame, then presents it one       |
// | sample at a time. Optional STREAM_IN_LEN_CHECK_EN adds frame-length  |
// | checking with err_len pulses and a FLUSH state.                      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module stream_in_loader #(
    parameter int CHAR_LEN   = 8,
    parameter int N          = 10,
    parameter int BATCH_SIZE = 2,
    localparam int IDX_W     = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1
) (
    input  wire logic              ACLK,
    input  wire logic              ARESETN,
    stream_in_loader_if.slave      s_axis,
    input  wire logic              next,
    input  wire logic              clear,
    output logic                   q_valid,
    output logic [N*CHAR_LEN-1:0]  q_data,
    output logic [IDX_W-1:0]       q_idx,
    output logic                   err_len
);
    localparam int COL_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_FULL  = 2'd1;
`ifdef STREAM_IN_LEN_CHECK_EN
    localparam logic [1:0] c_ST_FLUSH = 2'd2;
`endif

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [IDX_W-1:0]      r_wr_row;
    logic [COL_W-1:0]      r_wr_col;
    logic [IDX_W-1:0]      r_rd_idx;
    logic                  r_err_len;
    logic                  w_err;
    logic                  w_early;
    logic                  w_tready;
    logic                  w_beat;
    logic                  w_last_pos;
    logic                  w_rd_last;

    // One row per sample; rows are never reset, only the pointers are.
    logic [N*CHAR_LEN-1:0] r_buf [BATCH_SIZE];

    assign w_beat     = s_axis.tvalid && w_tready;
    assign w_last_pos = (r_wr_row == IDX_W'(BATCH_SIZE - 1)) && (r_wr_col == COL_W'(N - 1));
    assign w_rd_last  = (r_rd_idx == IDX_W'(BATCH_SIZE - 1));

    // State register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state   <= c_ST_EMPTY;
            r_err_len <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_err_len <= w_err;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        w_early     = 1'b0;
        if (clear) begin
            w_state_nxt = c_ST_EMPTY;
        end else begin
            case (r_state)
                c_ST_EMPTY: begin
                    if (w_beat) begin
`ifdef STREAM_IN_LEN_CHECK_EN
                        if (s_axis.tlast && !w_last_pos) begin
                            w_err   = 1'b1;
                            w_early = 1'b1;
                        end else if (w_last_pos && !s_axis.tlast) begin
                            w_err       = 1'b1;
                            w_state_nxt = c_ST_FLUSH;
                        end else if (w_last_pos) begin
                            w_state_nxt = c_ST_FULL;
                        end
`else
                        if (w_last_pos) begin
                            w_state_nxt = c_ST_FULL;
                        end
`endif
                    end
                end
                c_ST_FULL: begin
                    if (next && w_rd_last) begin
                        w_state_nxt = c_ST_EMPTY;
                    end
                end
`ifdef STREAM_IN_LEN_CHECK_EN
                c_ST_FLUSH: begin
                    if (w_beat && s_axis.tlast) begin
                        w_state_nxt = c_ST_EMPTY;
                    end
                end
`endif
                default: w_state_nxt = c_ST_EMPTY;
            endcase
        end
    end

    // Output decode from the state register only (no TVALID->TREADY path)
    always_comb begin
`ifdef STREAM_IN_LEN_CHECK_EN
        w_tready = (r_state == c_ST_EMPTY) || (r_state == c_ST_FLUSH);
`else
        w_tready = (r_state == c_ST_EMPTY);
`endif
        s_axis.tready = w_tready;
        q_valid       = (r_state == c_ST_FULL);
        q_idx         = r_rd_idx;
        q_data        = r_buf[r_rd_idx];
        err_len       = r_err_len;
    end

    // Write/read pointers
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wr_row <= '0;
            r_wr_col <= '0;
            r_rd_idx <= '0;
        end else if (clear) begin
            r_wr_row <= '0;
            r_wr_col <= '0;
            r_rd_idx <= '0;
        end else if (r_state == c_ST_EMPTY) begin
            if (w_beat) begin
                if (w_last_pos || w_early) begin
                    r_wr_row <= '0;
                    r_wr_col <= '0;
                    r_rd_idx <= '0;
                end else if (r_wr_col == COL_W'(N - 1)) begin
                    r_wr_col <= '0;
                    r_wr_row <= r_wr_row + IDX_W'(1);
                end else begin
                    r_wr_col <= r_wr_col + COL_W'(1);
                end
            end
        end else if (r_state == c_ST_FULL) begin
            if (next) begin
                r_rd_idx <= w_rd_last ? '0 : r_rd_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!clear && (r_state == c_ST_EMPTY) && w_beat) begin
            r_buf[r_wr_row][r_wr_col*CHAR_LEN +: CHAR_LEN] <= s_axis.tdata;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_stream_in_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_stream_in_loader                                                  |
// | Scoreboard bench: expected samples queued by stimulus, popped by a   |
// | monitor whenever a new sample appears on q_data.                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_stream_in_loader;
    localparam int CL = 8;
    localparam int NN = 10;
    localparam int BS = 2;

    typedef struct {
        logic [NN*CL-1:0] data;
        logic             idx;
    } sample_t;

    logic            ACLK = 1'b0;
    logic            ARESETN = 1'b0;
    logic            next = 1'b0;
    logic            clear = 1'b0;
    logic            q_valid;
    logic [NN*CL-1:0] q_data;
    logic [0:0]      q_idx;
    logic            err_len;

    int total = 0;
    int bad   = 0;
    int err_cnt = 0;
    bit qv_seen = 0;
    bit prev_valid = 0;
    logic [0:0] prev_idx = '0;
    sample_t exp_q[$];

    stream_in_loader_if #(.CHAR_LEN(CL)) s_axis ();

    stream_in_loader #(.CHAR_LEN(CL), .N(NN), .BATCH_SIZE(BS)) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .s_axis  (s_axis),
        .next    (next),
        .clear   (clear),
        .q_valid (q_valid),
        .q_data  (q_data),
        .q_idx   (q_idx),
        .err_len (err_len)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected samples for a frame whose beat i carries base+i.
    task automatic push_frame(input logic [7:0] base);
        sample_t s;
        for (int r = 0; r < BS; r++) begin
            for (int k = 0; k < NN; k++) s.data[k*CL +: CL] = base + 8'(r*NN + k);
            s.idx = 1'(r);
            exp_q.push_back(s);
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input logic l);
        int n = 0;
        while (!s_axis.tready && n < 50) begin
            @(posedge ACLK); #1;
            n++;
        end
        if (!s_axis.tready) check("tready_timeout", 32'(s_axis.tready), 32'd1);
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = d;
        s_axis.tlast  = l;
        @(posedge ACLK); #1;
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] base);
        for (int i = 0; i < BS*NN; i++) send_beat(base + 8'(i), i == BS*NN-1);
    endtask

    task automatic pulse_next();
        next = 1'b1;
        @(posedge ACLK); #1;
        next = 1'b0;
    endtask

    task automatic idle(input int c);
        for (int i = 0; i < c; i++) begin
            @(posedge ACLK); #1;
        end
    endtask

    // Monitor: a fresh sample is a rising q_valid or a change of q_idx.
    always @(negedge ACLK) begin
        sample_t e;
        if (ARESETN && q_valid && (!prev_valid || q_idx != prev_idx)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got idx=%0d data=%h expected no sample", q_idx, q_data);
            end else begin
                e = exp_q.pop_front();
                if (q_data !== e.data || q_idx !== e.idx) begin
                    bad++;
                    $display("FAIL sb_sample: got idx=%0d data=%h expected idx=%0d data=%h",
                             q_idx, q_data, e.idx, e.data);
                end
            end
        end
        if (err_len) err_cnt++;
        if (q_valid) qv_seen = 1;
        prev_valid = q_valid;
        prev_idx   = q_idx;
    end

    initial begin
        int e0;
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        s_axis.tdata  = '0;
        idle(3);
        ARESETN = 1'b1;
        idle(1);
        check("rst_tready", 32'(s_axis.tready), 32'd1);
        check("rst_qvalid", 32'(q_valid), 32'd0);
        check("rst_qidx",   32'(q_idx),   32'd0);
        check("rst_err",    32'(err_len), 32'd0);

        // Basic frame 0x01..0x14, TVALID held high
        push_frame(8'h01);
        send_frame(8'h01);
        check("t1_qvalid_after_last", 32'(q_valid), 32'd1);
        check("t1_qidx0", 32'(q_idx), 32'd0);
        check("t1_tready_full", 32'(s_axis.tready), 32'd0);
        idle(2);
        check("t1_hold_qvalid", 32'(q_valid), 32'd1);
        pulse_next();
        check("t1_qidx1", 32'(q_idx), 32'd1);
        pulse_next();
        check("t1_drained_qvalid", 32'(q_valid), 32'd0);
        check("t1_drained_tready", 32'(s_axis.tready), 32'd1);

        // Back-to-back frame with a gap after every beat
        push_frame(8'h01);
        for (int i = 0; i < BS*NN; i++) begin
            if (i == BS*NN-1) check("t2_qvalid_before_last", 32'(q_valid), 32'd0);
            send_beat(8'h01 + 8'(i), i == BS*NN-1);
            if (i != BS*NN-1) idle(1);
        end
        check("t2_qvalid_after_last", 32'(q_valid), 32'd1);
        pulse_next();
        pulse_next();
        check("t2_drained", 32'(q_valid), 32'd0);

        // Reset mid-fill drops the partial frame
        for (int i = 0; i < 7; i++) send_beat(8'hA0 + 8'(i), 1'b0);
        ARESETN = 1'b0;
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        check("t3_rst_tready", 32'(s_axis.tready), 32'd1);
        check("t3_rst_qvalid", 32'(q_valid), 32'd0);
        push_frame(8'h31);
        send_frame(8'h31);
        check("t3_qvalid", 32'(q_valid), 32'd1);
        pulse_next();
        pulse_next();

        // clear and next together on the last sample
        push_frame(8'h51);
        send_frame(8'h51);
        pulse_next();
        check("t4_qidx1", 32'(q_idx), 32'd1);
        next  = 1'b1;
        clear = 1'b1;
        @(posedge ACLK); #1;
        next  = 1'b0;
        clear = 1'b0;
        check("t4_clear_qvalid", 32'(q_valid), 32'd0);
        check("t4_clear_qidx",   32'(q_idx),   32'd0);
        check("t4_clear_tready", 32'(s_axis.tready), 32'd1);

`ifdef STREAM_IN_LEN_CHECK_EN
        // Early TLAST on beat 5
        e0 = err_cnt;
        qv_seen = 0;
        for (int i = 0; i < 5; i++) send_beat(8'hC0 + 8'(i), i == 4);
        idle(2);
        check("t5_err_pulses", 32'(err_cnt - e0), 32'd1);
        check("t5_no_qvalid", 32'(qv_seen), 32'd0);
        push_frame(8'h61);
        send_frame(8'h61);
        check("t5_reload_qvalid", 32'(q_valid), 32'd1);
        pulse_next();
        pulse_next();

        // Missing TLAST: 23 beats, TLAST only on the 23rd
        e0 = err_cnt;
        qv_seen = 0;
        for (int i = 0; i < 23; i++) begin
            check("t6_tready_flush", 32'(s_axis.tready), 32'd1);
            send_beat(8'hE0 + 8'(i), i == 22);
        end
        idle(1);
        check("t6_err_pulses", 32'(err_cnt - e0), 32'd1);
        check("t6_no_qvalid", 32'(qv_seen), 32'd0);
        check("t6_empty_tready", 32'(s_axis.tready), 32'd1);
        push_frame(8'h71);
        send_frame(8'h71);
        pulse_next();
        pulse_next();
`else
        e0 = 0;
        check("err_never", 32'(err_cnt + e0), 32'd0);
`endif

        idle(3);
        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
